right_shift_pipe: RTL and testbench

Parametrised, pipelined right-shift/rotate unit for the miner datapath. It is the next generation of the 32-bit combinational right barrel shifter. It adds configurable width, one register stage per shift-amount bit, a mode select (logical shift, arithmetic shift, rotate) and a valid/ready handshake with a tag sideband. It feeds the SHA-256 sigma/Sigma logic, which needs ROTR and SHR at full clock rate without a long combinational shift path.

---
 rtl/right_shift_pipe.sv | 105 ++++++++++
 tb/tb_right_shift_pipe.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/right_shift_pipe.sv
// Pipelined right shift / arithmetic shift / rotate, one stage per shamt bit.
// Define RSHIFT_ROTATE_EN to build rotate; otherwise mode 10 acts as SRL.
module right_shift_pipe #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH),
   parameter int TAG_W   = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_mode,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int L = SHAMT_W;

   typedef struct packed {
      logic               v;
      logic               sgn;
      logic [1:0]         mode;
      logic [SHAMT_W-1:0] shamt;
      logic [TAG_W-1:0]   tag;
      logic [WIDTH-1:0]   data;
   } stage_t;

   stage_t entry;
   stage_t stageD [L];
   stage_t stageQ [L];
   logic   advance;

   // Stage k handles shamt bit L-1-k, so the largest shift goes first.
   function automatic stage_t shiftStage(input stage_t cur, input int k);
      stage_t           res;
      int               sh;
      logic [WIDTH-1:0] srl;
      logic [WIDTH-1:0] sra;
`ifdef RSHIFT_ROTATE_EN
      logic [WIDTH-1:0] rot;
`endif
      sh  = 1 << (L - 1 - k);
      res = cur;
      srl = cur.data >> sh;
      sra = srl | ({WIDTH{cur.sgn}} << (WIDTH - sh));
`ifdef RSHIFT_ROTATE_EN
      rot = srl | (cur.data << (WIDTH - sh));
`endif
      if (cur.shamt[L-1-k]) begin
         unique case (cur.mode)
            2'b01:   res.data = sra;
`ifdef RSHIFT_ROTATE_EN
            2'b10:   res.data = rot;
`endif
            default: res.data = srl;
         endcase
      end
      return res;
   endfunction

   assign advance  = !stageQ[L-1].v || out_ready;
   assign in_ready = advance;

   always_comb begin
      entry       = '0;
      entry.v     = in_valid;
      entry.sgn   = in_data[WIDTH-1];
      entry.mode  = in_mode;
      entry.shamt = in_shamt;
      entry.tag   = in_tag;
      entry.data  = in_data;
   end

   for (genvar k = 0; k < L; k++) begin : g_stage
      if (k == 0) begin : g_first
         assign stageD[k] = shiftStage(entry, k);
      end else begin : g_rest
         assign stageD[k] = shiftStage(stageQ[k-1], k);
      end
   end

   // The last stage only loads on a valid entry so out_data holds across bubbles.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < L; k++) stageQ[k] <= '0;
      end else if (advance) begin
         for (int k = 0; k < L - 1; k++) stageQ[k] <= stageD[k];
         stageQ[L-1].v <= stageD[L-1].v;
         if (stageD[L-1].v) begin
            stageQ[L-1].data <= stageD[L-1].data;
            stageQ[L-1].tag  <= stageD[L-1].tag;
         end
      end
   end

   assign out_valid = stageQ[L-1].v;
   assign out_data  = stageQ[L-1].data;
   assign out_tag   = stageQ[L-1].tag;

endmodule

// File: tb/tb_right_shift_pipe.sv
// Scoreboard bench for right_shift_pipe (WIDTH 32, TAG_W 4).
// Expected values follow RSHIFT_ROTATE_EN the same way the design does.
module tb_right_shift_pipe;

   localparam int W  = 32;
   localparam int SW = 5;
   localparam int TW = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic [SW-1:0] in_shamt = '0;
   logic [1:0]    in_mode = '0;
   logic [TW-1:0] in_tag = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_data;
   logic [TW-1:0] out_tag;

   typedef struct {
      logic [W-1:0]  data;
      logic [TW-1:0] tag;
      int            acc;
      bit            lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   stepCnt = 0;
   bit   latMode = 1'b0;

`ifdef RSHIFT_ROTATE_EN
   localparam logic [W-1:0] ROT1 = 32'hC000_0000;
   localparam logic [W-1:0] ROT4 = 32'hF000_0000;
`else
   localparam logic [W-1:0] ROT1 = 32'h4000_0000;
   localparam logic [W-1:0] ROT4 = 32'h0000_0000;
`endif

   right_shift_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_shamt(in_shamt),
      .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic [W-1:0] refShift(input logic [W-1:0] d,
                                             input int s,
                                             input logic [1:0] m);
      case (m)
         2'b01: return $signed(d) >>> s;
`ifdef RSHIFT_ROTATE_EN
         2'b10: return (d >> s) | (d << (W - s));
`endif
         default: return d >> s;
      endcase
   endfunction

   task automatic step(input bit rst, input bit v, input logic [W-1:0] d,
                       input logic [SW-1:0] s, input logic [1:0] m,
                       input logic [TW-1:0] t, input bit ordy,
                       input logic [W-1:0] exp);
      exp_t e;
      @(negedge clock);
      stepCnt++;
      out_ready = ordy;
      #1;
      if (out_valid) begin
         if (sb.size() == 0) begin
            check("stale", out_valid, 0);
         end else if (out_ready) begin
            e = sb.pop_front();
            check("data", out_data, e.data);
            check("tag", out_tag, e.tag);
            if (e.lat) check("latency", stepCnt - e.acc, 5);
         end else begin
            check("stallData", out_data, sb[0].data);
            check("stallTag", out_tag, sb[0].tag);
            check("stallReady", in_ready, 0);
         end
      end
      reset    = rst;
      in_valid = v;
      in_data  = d;
      in_shamt = s;
      in_mode  = m;
      in_tag   = t;
      #1;
      if (rst) sb.delete();
      else if (v && in_ready) sb.push_back('{exp, t, stepCnt, latMode});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, '0, 1, '0);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() > 0; i++) idle(1);
      check("drain", sb.size(), 0);
   endtask

   task automatic randOp(input bit ordy);
      logic [W-1:0]  d;
      logic [SW-1:0] s;
      logic [1:0]    m;
      logic [TW-1:0] t;
      d = $urandom;
      s = SW'($urandom_range(0, W - 1));
      m = 2'($urandom_range(0, 3));
      t = TW'($urandom_range(0, 15));
      step(0, 1, d, s, m, t, ordy, refShift(d, int'(s), m));
   endtask

   initial begin
      step(1, 1, 32'hDEAD_BEEF, 5'd3, 2'b00, 4'd1, 1, '0);
      step(1, 0, '0, '0, '0, '0, 1, '0);
      @(posedge clock);
      #1;
      check("rstValid", out_valid, 0);
      check("rstData", out_data, 0);
      check("rstTag", out_tag, 0);
      check("rstReady", in_ready, 1);

      latMode = 1'b1;
      step(0, 1, 32'h8000_0001, 5'd1, 2'b10, 4'd3, 1, ROT1);
      idle(7);
      latMode = 1'b0;

      step(0, 1, 32'h8000_0000, 5'd31, 2'b01, 4'd5, 1, 32'hFFFF_FFFF);
      step(0, 1, 32'h8000_0000, 5'd4, 2'b00, 4'd6, 1, 32'h0800_0000);
      step(0, 1, 32'h1234_5678, 5'd0, 2'b10, 4'd7, 1, 32'h1234_5678);
      step(0, 1, 32'hF000_0000, 5'd4, 2'b11, 4'd8, 1, 32'h0F00_0000);
      step(0, 1, 32'h4000_0000, 5'd2, 2'b01, 4'd9, 1, 32'h1000_0000);
      step(0, 1, 32'h0000_000F, 5'd4, 2'b10, 4'd10, 1, ROT4);
      step(0, 1, 32'h8765_4321, 5'd0, 2'b01, 4'd11, 1, 32'h8765_4321);
      drain();

      for (int i = 0; i < 64; i++) begin
         randOp(1);
         check("inReady", in_ready, 1);
      end
      drain();

      for (int i = 0; i < 8; i++) randOp(1);
      for (int i = 0; i < 7; i++) begin
         randOp(0);
         check("stallValid", out_valid, 1);
      end
      for (int i = 0; i < 10; i++) randOp(1);
      drain();

      for (int i = 0; i < 3; i++) randOp(1);
      step(1, 1, 32'hFFFF_0000, 5'd8, 2'b01, 4'd2, 1, '0);
      step(0, 0, '0, '0, '0, '0, 1, '0);
      check("rstFlush", out_valid, 0);
      idle(12);
      step(0, 1, 32'h0000_0100, 5'd8, 2'b00, 4'd12, 1, 32'h0000_0001);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
